prbs7_checker: RTL

//   Receive-side checker for the channel's PRBS-7 test stream (x^7 + x^6 + 1).

---
 rtl/prbs7_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/prbs7_checker.sv
// PRBS-7 (x^7 + x^6 + 1) receive checker: self-synchronises, then counts bit
// errors against the locally predicted sequence and drops lock on error bursts.
module prbs7_checker #(
   parameter int unsigned SYNC_LEN   = 16,
   parameter int unsigned WINDOW     = 128,
   parameter int unsigned LOL_THRESH = 8,
   parameter int unsigned COUNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               rx_valid,
   input  logic               rx_bit,
   input  logic               clear_counts,
   output logic               locked,
   output logic               bit_err,
   output logic [COUNT_W-1:0] err_count,
   output logic [COUNT_W-1:0] bit_count
);

   localparam int unsigned SR_W  = 7;
   localparam int unsigned RUN_W = $clog2(SYNC_LEN + 1);
   localparam int unsigned WIN_W = $clog2(WINDOW + 1);
   localparam int unsigned ERR_W = $clog2(LOL_THRESH + 1);

   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]         r_state,     w_state_nxt;
   logic [SR_W-1:0]    r_sr,        w_sr_nxt;
   logic [RUN_W-1:0]   r_run,       w_run_nxt;
   logic [WIN_W-1:0]   r_win_cnt,   w_win_cnt_nxt;
   logic [ERR_W-1:0]   r_win_err,   w_win_err_nxt;
   logic               r_locked,    w_locked_nxt;
   logic               r_bit_err,   w_bit_err_nxt;
   logic [COUNT_W-1:0] r_err_count, w_err_count_nxt;
   logic [COUNT_W-1:0] r_bit_count, w_bit_count_nxt;

   logic               w_pred;
   logic               w_mis;
   logic [WIN_W-1:0]   w_win_cnt_inc;
   logic [ERR_W-1:0]   w_win_err_inc;

   assign w_pred        = r_sr[6] ^ r_sr[5];
   assign w_mis         = rx_bit ^ w_pred;
   assign w_win_cnt_inc = r_win_cnt + 1'b1;
   assign w_win_err_inc = r_win_err + ERR_W'(w_mis);

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_sr_nxt        = r_sr;
      w_run_nxt       = r_run;
      w_win_cnt_nxt   = r_win_cnt;
      w_win_err_nxt   = r_win_err;
      w_bit_err_nxt   = 1'b0;
      w_err_count_nxt = r_err_count;
      w_bit_count_nxt = r_bit_count;

      if (rx_valid) begin
         case (r_state)
            ST_HUNT: begin
               w_sr_nxt = {r_sr[5:0], rx_bit};
               // An all-zero register is the PRBS lock-up state and never matches
               if ((r_sr != '0) && !w_mis) begin
                  if (r_run == RUN_W'(SYNC_LEN - 1)) begin
                     w_state_nxt   = ST_LOCKED;
                     w_run_nxt     = '0;
                     w_win_cnt_nxt = '0;
                     w_win_err_nxt = '0;
                  end else begin
                     w_run_nxt = r_run + 1'b1;
                  end
               end else begin
                  w_run_nxt = '0;
               end
            end
            default: begin
               w_sr_nxt = {r_sr[5:0], w_pred};
               if (r_bit_count != '1) w_bit_count_nxt = r_bit_count + 1'b1;
               if (w_mis) begin
                  w_bit_err_nxt = 1'b1;
                  if (r_err_count != '1) w_err_count_nxt = r_err_count + 1'b1;
               end
               w_win_cnt_nxt = w_win_cnt_inc;
               w_win_err_nxt = w_win_err_inc;
               // Re-seed from the line on loss of lock so hunting starts immediately
               if (w_win_err_inc == ERR_W'(LOL_THRESH)) begin
                  w_state_nxt = ST_HUNT;
                  w_run_nxt   = '0;
                  w_sr_nxt    = {r_sr[5:0], rx_bit};
               end else if (w_win_cnt_inc == WIN_W'(WINDOW)) begin
                  w_win_cnt_nxt = '0;
                  w_win_err_nxt = '0;
               end
            end
         endcase
      end

      if (clear_counts) begin
         w_err_count_nxt = '0;
         w_bit_count_nxt = '0;
      end

      w_locked_nxt = (w_state_nxt == ST_LOCKED);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_HUNT;
         r_sr        <= '0;
         r_run       <= '0;
         r_win_cnt   <= '0;
         r_win_err   <= '0;
         r_locked    <= 1'b0;
         r_bit_err   <= 1'b0;
         r_err_count <= '0;
         r_bit_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sr        <= w_sr_nxt;
         r_run       <= w_run_nxt;
         r_win_cnt   <= w_win_cnt_nxt;
         r_win_err   <= w_win_err_nxt;
         r_locked    <= w_locked_nxt;
         r_bit_err   <= w_bit_err_nxt;
         r_err_count <= w_err_count_nxt;
         r_bit_count <= w_bit_count_nxt;
      end
   end

   assign locked    = r_locked;
   assign bit_err   = r_bit_err;
   assign err_count = r_err_count;
   assign bit_count = r_bit_count;

endmodule
